galaxian_dl_ctrl: RTL and testbench

Download sequencer between the HPS loader stream and the Galaxian core. Demultiplexes `ioctl` writes into the ROM write port, the game-select (`mod`) register and the 8-byte DIP bank. Buffers ROM bytes in a small FIFO so that a ROM port that stalls can backpressure the loader through `ioctl_wait`. Holds the core in reset during a ROM or mod download and for a fixed settle period afterwards.

---
 rtl/galaxian_dl_pkg.sv | 20 ++
 rtl/dl_fifo.sv | 68 ++++++
 rtl/galaxian_dl_ctrl.sv | 166 ++++++++++++++++
 tb/tb_galaxian_dl_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/galaxian_dl_pkg.sv
// Shared definitions for the Galaxian download sequencer.
//   dl_state_t : controller FSM states
//   IDX_*      : ioctl stream indices routed by the controller
//   DIP_BYTES  : size of the DIP switch bank in bytes
package galaxian_dl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,  // core held in reset while the settle counter runs
    ST_IDLE  = 2'd1,  // core running, waiting for a ROM or mod download
    ST_LOAD  = 2'd2,  // loader session active
    ST_DRAIN = 2'd3   // session ended, FIFO still emptying into the ROM port
  } dl_state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  localparam int DIP_BYTES = 8;

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO with show-ahead output.
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   push, din        : write request and data (ignored when full unless popping)
//   pop              : read request (ignored when empty)
//   dout             : head entry, valid while empty is 0
//   full, empty      : occupancy flags
//   count            : number of stored entries, 0..DEPTH
// DEPTH must be a power of two, at least 2; pointers wrap naturally.
module dl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the head slot first, so a push into a full FIFO is still
  // accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define which
  // entries are valid, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/galaxian_dl_ctrl.sv
// Download sequencer between the HPS loader stream and the Galaxian core.
// Ports:
//   clk_sys, reset_n        : 12 MHz system clock, asynchronous active-low reset
//   ioctl_download/index/wr/addr/dout : loader stream (index 0 ROM, 1 mod, 254 DIP)
//   ioctl_wait              : registered stall request back to the loader
//   dn_addr/dn_data/dn_wr   : ROM write port, valid/ready with dn_ready
//   mod                     : game select byte (last byte of index 1 wins)
//   dip                     : 8-byte DIP bank, byte k at dip[8k+7:8k]
//   core_reset              : high in every state except IDLE
//   err_ovf, err_range      : sticky error flags, cleared when a download starts
module galaxian_dl_ctrl
  import galaxian_dl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1024,
  parameter int ROM_AW      = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ioctl_download,
  input  logic [7:0]               ioctl_index,
  input  logic                     ioctl_wr,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  output logic                     ioctl_wait,
  output logic [ROM_AW-1:0]        dn_addr,
  output logic [7:0]               dn_data,
  output logic                     dn_wr,
  input  logic                     dn_ready,
  output logic [7:0]               mod,
  output logic [8*DIP_BYTES-1:0]   dip,
  output logic                     core_reset,
  output logic                     err_ovf,
  output logic                     err_range
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int FW  = ROM_AW + 8;
  // Stall once only one free slot remains: that slot absorbs the write the
  // loader may already have in flight when it sees ioctl_wait.
  localparam logic [FAW:0] WAIT_LVL = (FAW+1)'(FIFO_DEPTH - 1);
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYCLES - 1);

  dl_state_t       state;
  dl_state_t       state_next;
  logic [HCW-1:0]  hold_cnt;

  logic            fifo_full;
  logic            fifo_empty;
  logic [FAW:0]    fifo_count;
  logic [FW-1:0]   fifo_dout;
  logic            fifo_push;
  logic            fifo_pop;

  logic            rom_wr;
  logic            rom_in_range;
  logic            mod_wr;
  logic            dip_wr;
  logic            qual_dl;
  logic            load_entry;

  // Write decode
  assign rom_wr       = ioctl_wr && (ioctl_index == IDX_ROM);
  assign rom_in_range = (ioctl_addr[24:ROM_AW] == '0);
  assign mod_wr       = ioctl_wr && (ioctl_index == IDX_MOD);
  assign dip_wr       = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == '0);

  assign fifo_push = rom_wr && rom_in_range;
  assign fifo_pop  = dn_wr && dn_ready;

  // Only ROM and mod sessions reset the core; DIP updates apply live.
  assign qual_dl = ioctl_download && ((ioctl_index == IDX_ROM) || (ioctl_index == IDX_MOD));

  dl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     ({ioctl_addr[ROM_AW-1:0], ioctl_dout}),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The head entry is held until popped, so the port stays stable while stalled.
  assign dn_wr              = !fifo_empty;
  assign {dn_addr, dn_data} = fifo_dout;

  assign core_reset = (state != ST_IDLE);
  assign load_entry = (state_next == ST_LOAD) && (state != ST_LOAD);

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (qual_dl) state_next = ST_LOAD;
      ST_LOAD:  if (!ioctl_download) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (qual_dl)         state_next = ST_LOAD;
        else if (fifo_empty) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (qual_dl)               state_next = ST_LOAD;
        else if (hold_cnt == '0)   state_next = ST_IDLE;
      end
      default: state_next = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_HOLD;
      hold_cnt <= HOLD_INIT;
    end else begin
      state <= state_next;
      // Outside HOLD the counter sits at its start value, so every HOLD entry
      // begins a full settle period and an interrupted one is discarded.
      if (state != ST_HOLD) begin
        hold_cnt <= HOLD_INIT;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HCW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_wait <= 1'b0;
    end else begin
      ioctl_wait <= (fifo_count >= WAIT_LVL);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mod <= '0;
      dip <= '1;
    end else begin
      if (mod_wr) mod <= ioctl_dout;
      if (dip_wr) dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

  // A byte arriving on the same edge a new session starts belongs to that
  // session, so setting a flag takes priority over the entry clear.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      err_ovf   <= 1'b0;
      err_range <= 1'b0;
    end else begin
      if (load_entry) begin
        err_ovf   <= 1'b0;
        err_range <= 1'b0;
      end
      if (fifo_push && fifo_full && !fifo_pop) err_ovf   <= 1'b1;
      if (rom_wr && !rom_in_range)             err_range <= 1'b1;
    end
  end

endmodule

// File: tb/tb_galaxian_dl_ctrl.sv
// Directed testbench for galaxian_dl_ctrl with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge or right after the rising edge.
module tb_galaxian_dl_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_ready;
  logic [7:0]  mod;
  logic [63:0] dip;
  logic        core_reset;
  logic        err_ovf;
  logic        err_range;

  int n_pass  = 0;
  int n_total = 0;

  logic        mon_en = 1'b0;
  logic [23:0] mon_q[$];

  galaxian_dl_ctrl #(
    .FIFO_DEPTH  (4),
    .HOLD_CYCLES (1024),
    .ROM_AW      (16)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_ready       (dn_ready),
    .mod            (mod),
    .dip            (dip),
    .core_reset     (core_reset),
    .err_ovf        (err_ovf),
    .err_range      (err_range)
  );

  always #5 clk_sys = ~clk_sys;

  // Record every completed ROM transfer (sampled before the completing edge).
  always @(negedge clk_sys) begin
    if (mon_en && dn_wr && dn_ready) mon_q.push_back({dn_addr, dn_data});
  end

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_sys);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (core_reset === 1'b0) break;
      next_cycle();
    end
    n_total++;
    if (core_reset !== 1'b0) $display("FAIL wait_idle: core_reset=%b want 0 within 3000 cycles", core_reset);
    else n_pass++;
  endtask

  task automatic test_reset();
    int k;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    dn_ready       = 1'b1;
    #23;
    n_total++; if (core_reset !== 1'b1) $display("FAIL rst_core_reset: got %b want 1", core_reset); else n_pass++;
    n_total++; if (dn_wr !== 1'b0) $display("FAIL rst_dn_wr: got %b want 0", dn_wr); else n_pass++;
    n_total++; if (ioctl_wait !== 1'b0) $display("FAIL rst_wait: got %b want 0", ioctl_wait); else n_pass++;
    n_total++; if (mod !== 8'h00) $display("FAIL rst_mod: got %h want 00", mod); else n_pass++;
    n_total++; if (dip !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rst_dip: got %h want all ones", dip); else n_pass++;
    n_total++; if ({err_ovf, err_range} !== 2'b00) $display("FAIL rst_err: got %b want 00", {err_ovf, err_range}); else n_pass++;
    next_cycle();
    reset_n = 1'b1;
    k = 0;
    for (int i = 0; i < 2000; i++) begin
      next_cycle();
      k++;
      if (core_reset !== 1'b1) break;
    end
    n_total++; if (k != 1024) $display("FAIL rst_hold_len: got %0d cycles want 1024", k); else n_pass++;
    n_total++; if (core_reset !== 1'b0) $display("FAIL rst_release: core_reset=%b want 0", core_reset); else n_pass++;
  endtask

  task automatic test_stream_ready();
    logic [15:0] exp_a;
    logic [7:0]  exp_d;
    dn_ready       = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(i);
        ioctl_dout = 8'(8'hA0 + i);
      end else begin
        ioctl_wr = 1'b0;
      end
      // The final byte shares its cycle with the end of the session.
      if (i == 15) ioctl_download = 1'b0;
      mid();
      n_total++; if (ioctl_wait !== 1'b0) $display("FAIL stream_wait c%0d: got %b want 0", i, ioctl_wait); else n_pass++;
      if (i == 0) begin
        n_total++; if (dn_wr !== 1'b0) $display("FAIL stream_first_dn_wr: got %b want 0", dn_wr); else n_pass++;
      end else begin
        exp_a = 16'(i - 1);
        exp_d = 8'(8'hA0 + i - 1);
        n_total++;
        if (dn_wr !== 1'b1 || dn_addr !== exp_a || dn_data !== exp_d)
          $display("FAIL stream_xfer c%0d: got wr=%b a=%h d=%h want wr=1 a=%h d=%h", i, dn_wr, dn_addr, dn_data, exp_a, exp_d);
        else n_pass++;
      end
      next_cycle();
    end
    mid();
    n_total++; if (dn_wr !== 1'b0) $display("FAIL stream_done_dn_wr: got %b want 0", dn_wr); else n_pass++;
    next_cycle();
    wait_idle();
  endtask

  task automatic test_backpressure();
    int sent;
    int first_wait;
    logic [23:0] exp;
    mon_q.delete();
    mon_en         = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    sent           = 0;
    first_wait     = -1;
    for (int c = 0; c < 200 && (sent < 16 || mon_q.size() < 16); c++) begin
      dn_ready = (c >= 20);
      if (ioctl_wait === 1'b1 && first_wait < 0) first_wait = c;
      if (ioctl_wait === 1'b0 && sent < 16) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(sent);
        ioctl_dout = 8'(8'h50 + sent);
        sent++;
      end else begin
        ioctl_wr = 1'b0;
      end
      next_cycle();
    end
    ioctl_wr = 1'b0;
    n_total++; if (first_wait != 4) $display("FAIL bp_wait_rise: got cycle %0d want 4", first_wait); else n_pass++;
    n_total++; if (mon_q.size() != 16) $display("FAIL bp_count: got %0d transfers want 16", mon_q.size()); else n_pass++;
    for (int j = 0; j < 16 && j < mon_q.size(); j++) begin
      exp = {16'(j), 8'(8'h50 + j)};
      n_total++; if (mon_q[j] !== exp) $display("FAIL bp_order[%0d]: got %h want %h", j, mon_q[j], exp); else n_pass++;
    end
    n_total++; if (err_ovf !== 1'b0) $display("FAIL bp_no_ovf: got %b want 0", err_ovf); else n_pass++;

    // Loader ignoring the stall: the fifth byte hits a full FIFO.
    mon_q.delete();
    dn_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(16'h20 + i);
      ioctl_dout = 8'(8'hC0 + i);
      mid();
      if (i == 4) begin
        n_total++; if (err_ovf !== 1'b0) $display("FAIL ovf_before: got %b want 0", err_ovf); else n_pass++;
        n_total++; if (ioctl_wait !== 1'b1) $display("FAIL ovf_wait_full: got %b want 1", ioctl_wait); else n_pass++;
      end
      next_cycle();
    end
    ioctl_wr = 1'b0;
    mid();
    n_total++; if (err_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", err_ovf); else n_pass++;
    next_cycle();
    dn_ready = 1'b1;
    for (int i = 0; i < 8; i++) next_cycle();
    n_total++; if (mon_q.size() != 4) $display("FAIL ovf_kept: got %0d transfers want 4", mon_q.size()); else n_pass++;
    for (int j = 0; j < 4 && j < mon_q.size(); j++) begin
      exp = {16'(16'h20 + j), 8'(8'hC0 + j)};
      n_total++; if (mon_q[j] !== exp) $display("FAIL ovf_order[%0d]: got %h want %h", j, mon_q[j], exp); else n_pass++;
    end
    ioctl_download = 1'b0;
    mon_en         = 1'b0;
    next_cycle();
    wait_idle();
  endtask

  task automatic test_range();
    mon_q.delete();
    mon_en         = 1'b1;
    dn_ready       = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h1_0000;
    ioctl_dout     = 8'h77;
    next_cycle();
    ioctl_wr = 1'b0;
    mid();
    n_total++; if (err_range !== 1'b1) $display("FAIL range_set: got %b want 1", err_range); else n_pass++;
    n_total++; if (err_ovf !== 1'b0) $display("FAIL range_ovf_cleared: got %b want 0", err_ovf); else n_pass++;
    n_total++; if (dn_wr !== 1'b0) $display("FAIL range_no_dn_wr: got %b want 0", dn_wr); else n_pass++;
    for (int i = 0; i < 3; i++) next_cycle();
    n_total++; if (mon_q.size() != 0) $display("FAIL range_dropped: got %0d transfers want 0", mon_q.size()); else n_pass++;
    mon_en         = 1'b0;
    ioctl_download = 1'b0;
    next_cycle();
    wait_idle();
    n_total++; if (err_range !== 1'b1) $display("FAIL range_sticky: got %b want 1", err_range); else n_pass++;
    ioctl_download = 1'b1;
    next_cycle();
    ioctl_download = 1'b0;
    mid();
    n_total++; if (err_range !== 1'b0) $display("FAIL range_clear: got %b want 0", err_range); else n_pass++;
    next_cycle();
    wait_idle();
  endtask

  task automatic test_hold_restart();
    int k;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    next_cycle();
    ioctl_download = 1'b0;
    next_cycle();
    for (int i = 0; i < 100; i++) next_cycle();
    n_total++; if (core_reset !== 1'b1) $display("FAIL restart_in_hold: core_reset=%b want 1", core_reset); else n_pass++;
    ioctl_download = 1'b1;
    next_cycle();
    ioctl_download = 1'b0;
    k = 0;
    for (int i = 0; i < 2000; i++) begin
      next_cycle();
      k++;
      if (core_reset !== 1'b1) break;
    end
    // One edge into DRAIN, one into HOLD, then a full 1024-cycle settle.
    n_total++; if (k != 1026) $display("FAIL restart_hold_len: got %0d cycles want 1026", k); else n_pass++;
  endtask

  task automatic test_mod();
    int k;
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'h33;
    next_cycle();
    ioctl_addr = 25'd1;
    ioctl_dout = 8'h0C;
    mid();
    n_total++; if (mod !== 8'h33) $display("FAIL mod_first: got %h want 33", mod); else n_pass++;
    n_total++; if (core_reset !== 1'b1) $display("FAIL mod_load_reset: got %b want 1", core_reset); else n_pass++;
    next_cycle();
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    mid();
    n_total++; if (mod !== 8'h0C) $display("FAIL mod_last_wins: got %h want 0c", mod); else n_pass++;
    k = 0;
    for (int i = 0; i < 2000; i++) begin
      next_cycle();
      k++;
      if (core_reset !== 1'b1) break;
    end
    n_total++; if (k != 1026) $display("FAIL mod_reset_len: got %0d cycles want 1026", k); else n_pass++;
    n_total++; if (mod !== 8'h0C) $display("FAIL mod_held: got %h want 0c", mod); else n_pass++;
  endtask

  task automatic test_dip();
    ioctl_index    = 8'd254;
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'd2;
    ioctl_dout     = 8'hA5;
    mid();
    n_total++; if (dip !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL dip_not_yet: got %h want all ones", dip); else n_pass++;
    next_cycle();
    ioctl_addr = 25'd8;
    ioctl_dout = 8'h00;
    mid();
    n_total++; if (dip[23:16] !== 8'hA5) $display("FAIL dip_byte2: got %h want a5", dip[23:16]); else n_pass++;
    n_total++; if (core_reset !== 1'b0) $display("FAIL dip_no_reset: got %b want 0", core_reset); else n_pass++;
    next_cycle();
    ioctl_addr = 25'd7;
    ioctl_dout = 8'h12;
    mid();
    n_total++; if (dip !== 64'hFFFF_FFFF_FFA5_FFFF) $display("FAIL dip_addr8_ignored: got %h want ffffffffffa5ffff", dip); else n_pass++;
    next_cycle();
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    mid();
    n_total++; if (dip !== 64'h12FF_FFFF_FFA5_FFFF) $display("FAIL dip_byte7: got %h want 12ffffffffa5ffff", dip); else n_pass++;
    n_total++; if (core_reset !== 1'b0) $display("FAIL dip_still_idle: got %b want 0", core_reset); else n_pass++;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_stream_ready();
    test_backpressure();
    test_range();
    test_hold_restart();
    test_mod();
    test_dip();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
